// File: rtl/dd2_sub_cpu_glue_if.sv
// Bus bundle between the Double Dragon 2 sub-CPU glue, the main CPU, the ROM port and the Z80 core.
// The glue logic uses the slave modport. The surrounding system or bench drives through the master modport.
interface dd2_sub_cpu_glue_if;
  // main CPU side
  logic        mcu_rstb;
  logic        main_cen;
  logic [8:0]  main_AB;
  logic        main_wrn;
  logic [7:0]  main_dout;
  logic [7:0]  shared_dout;
  logic        com_cs;
  logic        mcu_halt;
  logic        mcu_nmi_set;
  logic        mcu_ban;
  logic        mcu_irqmain;
  // game ROM port
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_cs;
  logic        rom_ok;
  // sub-CPU core
  logic        cen4;
  logic        cpu_rstn;
  logic        cpu_nmi_n;
  logic        cpu_busrq_n;
  logic        cpu_wait_n;
  logic        cpu_busak_n;
  logic        cpu_mreq_n;
  logic        cpu_wr_n;
  logic [15:0] cpu_A;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;

  modport slave (
    input  mcu_rstb, main_cen, main_AB, main_wrn, main_dout, com_cs, mcu_halt, mcu_nmi_set,
    input  rom_data, rom_ok, cen4, cpu_busak_n, cpu_mreq_n, cpu_wr_n, cpu_A, cpu_dout,
    output shared_dout, mcu_ban, mcu_irqmain, rom_addr, rom_cs,
    output cpu_rstn, cpu_nmi_n, cpu_busrq_n, cpu_wait_n, cpu_din
  );

  modport master (
    output mcu_rstb, main_cen, main_AB, main_wrn, main_dout, com_cs, mcu_halt, mcu_nmi_set,
    output rom_data, rom_ok, cen4, cpu_busak_n, cpu_mreq_n, cpu_wr_n, cpu_A, cpu_dout,
    input  shared_dout, mcu_ban, mcu_irqmain, rom_addr, rom_cs,
    input  cpu_rstn, cpu_nmi_n, cpu_busrq_n, cpu_wait_n, cpu_din
  );
endinterface

// File: rtl/dd2_sub_cpu_glue.sv
// Sub-CPU glue: reset sequencer, NMI latch, address decoder, ROM wait and dual-port shared RAM.
// Define SUB_SIM_MSG_EN for simulation messages on mcu_halt / mcu_nmi_set edges (logic unchanged).
module dd2_sub_cpu_glue #(
  parameter int RAM_AW = 10
) (
  input logic               clk,
  input logic               rst,
  dd2_sub_cpu_glue_if.slave bus
);

  // reset sequencer
  logic [3:0] cnt_q, cnt_d;
  logic       rstn_q, rstn_d;

  always_comb begin
    cnt_d  = cnt_q;
    rstn_d = rstn_q;
    if (bus.cen4) begin
      if (cnt_q != 4'd0) cnt_d  = cnt_q - 4'd1;
      else               rstn_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst | ~bus.mcu_rstb) begin
      cnt_q  <= 4'd15;
      rstn_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rstn_q <= rstn_d;
    end
  end

  // address decoder, qualified by mreq
  logic mreq;
  logic rom_cs;
  logic shared_cs;
  logic nmi_ack;
  logic irq_main;

  always_comb begin
    mreq      = ~bus.cpu_mreq_n;
    rom_cs    = mreq & (bus.cpu_A[15:14] != 2'b11);
    shared_cs = mreq & (bus.cpu_A[15:10] == 6'b110000);
    nmi_ack   = mreq & (bus.cpu_A[15:12] == 4'hD) & ~bus.cpu_wr_n;
    irq_main  = mreq & (bus.cpu_A[15:12] == 4'hE) & ~bus.cpu_wr_n;
  end

  // NMI latch: set on a rising edge of mcu_nmi_set, ack has priority
  logic nmi_last_q;
  logic nmi_q, nmi_d;

  always_comb begin
    nmi_d = nmi_q;
    if (!rstn_q)                              nmi_d = 1'b0;
    else if (nmi_ack)                         nmi_d = 1'b0;
    else if (bus.mcu_nmi_set && !nmi_last_q)  nmi_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_last_q <= 1'b0;
      nmi_q      <= 1'b0;
    end else begin
      nmi_last_q <= bus.mcu_nmi_set;
      nmi_q      <= nmi_d;
    end
  end

  // port A (sub-CPU): the write enable fires once, on the falling edge of wr_n
  logic              last_wr_n_q;
  logic              we_a_q;
  logic [RAM_AW-1:0] addr_a_q;
  logic [7:0]        din_a_q;
  logic [7:0]        q_a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr_n_q <= 1'b1;
      we_a_q      <= 1'b0;
    end else begin
      last_wr_n_q <= bus.cpu_wr_n;
      we_a_q      <= shared_cs & ~bus.cpu_wr_n & last_wr_n_q;
    end
    addr_a_q <= bus.cpu_A[RAM_AW-1:0];
    din_a_q  <= bus.cpu_dout;
  end

  // port B (main CPU): writes only land while the sub-CPU has granted the bus
  logic              we_b_q;
  logic [RAM_AW-1:0] addr_b_q;
  logic [7:0]        din_b_q;
  logic [7:0]        q_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      we_b_q <= 1'b0;
    end else if (bus.main_cen) begin
      we_b_q <= ~bus.main_wrn & bus.com_cs & ~bus.cpu_busak_n;
    end
    if (bus.main_cen) begin
      addr_b_q <= {{(RAM_AW-9){1'b0}}, bus.main_AB};
      din_b_q  <= bus.main_dout;
    end
  end

  // storage: port B is written last so it wins a same-address collision
  logic [7:0] mem [0:(2**RAM_AW)-1];

  always_ff @(posedge clk) begin
    if (we_a_q) mem[addr_a_q] <= din_a_q;
    if (we_b_q) mem[addr_b_q] <= din_b_q;
    q_a_q <= mem[addr_a_q];
    q_b_q <= mem[addr_b_q];
  end

  // outputs
  always_comb begin
    bus.cpu_rstn    = rstn_q;
    bus.cpu_nmi_n   = ~nmi_q;
    bus.cpu_busrq_n = ~bus.mcu_halt;
    bus.mcu_ban     = bus.cpu_busak_n;
    bus.mcu_irqmain = irq_main;
    bus.rom_addr    = bus.cpu_A;
    bus.rom_cs      = rom_cs;
    bus.cpu_wait_n  = ~(rom_cs & ~bus.rom_ok);
    bus.shared_dout = q_b_q;
    if (rom_cs)         bus.cpu_din = bus.rom_data;
    else if (shared_cs) bus.cpu_din = q_a_q;
    else                bus.cpu_din = 8'hFF;
  end

`ifdef SUB_SIM_MSG_EN
  logic halt_last_q;

  always_ff @(posedge clk) begin
    halt_last_q <= bus.mcu_halt;
    if (bus.mcu_halt && !halt_last_q) $display("MCU_HALT rose");
    if (!bus.mcu_halt && halt_last_q) $display("MCU_HALT fell");
    if (bus.mcu_nmi_set && !nmi_last_q) $display("MCU NMI set");
  end
`endif

endmodule

// File: tb/tb_dd2_sub_cpu_glue.sv
// Directed bench for dd2_sub_cpu_glue: reset sequencer, NMI latch, decoder, read mux and shared RAM.
module tb_dd2_sub_cpu_glue;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dd2_sub_cpu_glue_if bus ();

  dd2_sub_cpu_glue #(.RAM_AW(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cen4_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      bus.cen4 = 1'b1;
      tick();
      bus.cen4 = 1'b0;
      tick(); tick(); tick();
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sub_write(input logic [15:0] addr, input logic [7:0] data);
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_A      = addr;
    bus.cpu_dout   = data;
    bus.cpu_wr_n   = 1'b1;
    tick();
    bus.cpu_wr_n = 1'b0;
    tick(); tick();
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_mreq_n = 1'b1;
    tick();
  endtask

  task automatic sub_read(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_A      = addr;
    tick(); tick();
    chk(tag, {8'h00, bus.cpu_din}, {8'h00, exp});
    bus.cpu_mreq_n = 1'b1;
    tick();
  endtask

  task automatic main_write(input logic [8:0] addr, input logic [7:0] data);
    bus.main_AB   = addr;
    bus.main_dout = data;
    bus.main_wrn  = 1'b0;
    bus.com_cs    = 1'b1;
    bus.main_cen  = 1'b1;
    tick();
    bus.main_wrn = 1'b1;
    bus.com_cs   = 1'b0;
    tick();
    bus.main_cen = 1'b0;
    tick();
  endtask

  task automatic main_read(input string tag, input logic [8:0] addr, input logic [7:0] exp);
    bus.main_AB  = addr;
    bus.main_cen = 1'b1;
    tick();
    bus.main_cen = 1'b0;
    tick();
    chk(tag, {8'h00, bus.shared_dout}, {8'h00, exp});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.mcu_rstb    = 1'b1;
    bus.cen4        = 1'b0;
    bus.main_cen    = 1'b0;
    bus.main_AB     = '0;
    bus.main_wrn    = 1'b1;
    bus.main_dout   = '0;
    bus.com_cs      = 1'b0;
    bus.mcu_halt    = 1'b0;
    bus.mcu_nmi_set = 1'b0;
    bus.rom_data    = '0;
    bus.rom_ok      = 1'b0;
    bus.cpu_busak_n = 1'b1;
    bus.cpu_mreq_n  = 1'b1;
    bus.cpu_wr_n    = 1'b1;
    bus.cpu_A       = '0;
    bus.cpu_dout    = '0;
    tick(); tick(); tick();

    // reset state
    chk("rst_cpu_rstn", {15'd0, bus.cpu_rstn}, 16'd0);
    chk("rst_nmi_n", {15'd0, bus.cpu_nmi_n}, 16'd1);
    chk("rst_busrq_n", {15'd0, bus.cpu_busrq_n}, 16'd1);
    chk("rst_wait_n", {15'd0, bus.cpu_wait_n}, 16'd1);
    chk("rst_din_idle", {8'h00, bus.cpu_din}, 16'h00FF);
    chk("rst_irqmain", {15'd0, bus.mcu_irqmain}, 16'd0);
    chk("rst_ban", {15'd0, bus.mcu_ban}, 16'd1);

    // reset sequencer: 15 pulses keep it low, the 16th releases
    rst = 1'b0;
    cen4_pulses(15);
    chk("seq_after15", {15'd0, bus.cpu_rstn}, 16'd0);
    cen4_pulses(1);
    chk("seq_after16", {15'd0, bus.cpu_rstn}, 16'd1);

    // mcu_rstb mid-count restarts the count
    bus.mcu_rstb = 1'b0;
    tick();
    chk("rstb_assert", {15'd0, bus.cpu_rstn}, 16'd0);
    bus.mcu_rstb = 1'b1;
    cen4_pulses(8);
    bus.mcu_rstb = 1'b0;
    tick();
    bus.mcu_rstb = 1'b1;
    cen4_pulses(15);
    chk("restart_after15", {15'd0, bus.cpu_rstn}, 16'd0);
    cen4_pulses(1);
    chk("restart_after16", {15'd0, bus.cpu_rstn}, 16'd1);

    // NMI latch set, held level does not matter, ack at 0xD000 clears
    bus.mcu_nmi_set = 1'b1;
    tick();
    chk("nmi_set", {15'd0, bus.cpu_nmi_n}, 16'd0);
    tick();
    bus.mcu_nmi_set = 1'b0;
    tick();
    chk("nmi_held", {15'd0, bus.cpu_nmi_n}, 16'd0);
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_A      = 16'hD000;
    bus.cpu_wr_n   = 1'b0;
    tick();
    chk("nmi_ack", {15'd0, bus.cpu_nmi_n}, 16'd1);
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_mreq_n = 1'b1;
    tick();

    // edge and ack in the same clock: clear wins and the edge is consumed
    bus.mcu_nmi_set = 1'b1;
    bus.cpu_mreq_n  = 1'b0;
    bus.cpu_wr_n    = 1'b0;
    tick();
    chk("nmi_ack_wins", {15'd0, bus.cpu_nmi_n}, 16'd1);
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_mreq_n = 1'b1;
    tick();
    chk("nmi_no_reedge", {15'd0, bus.cpu_nmi_n}, 16'd1);
    bus.mcu_nmi_set = 1'b0;
    tick();

    // decoder and ROM wait
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_A      = 16'h1234;
    bus.rom_ok     = 1'b0;
    #1;
    chk("rom_cs_1234", {15'd0, bus.rom_cs}, 16'd1);
    chk("wait_rom_busy", {15'd0, bus.cpu_wait_n}, 16'd0);
    chk("rom_addr", bus.rom_addr, 16'h1234);
    bus.rom_ok   = 1'b1;
    bus.rom_data = 8'h5A;
    #1;
    chk("din_rom", {8'h00, bus.cpu_din}, 16'h005A);
    chk("wait_rom_ok", {15'd0, bus.cpu_wait_n}, 16'd1);
    bus.cpu_A = 16'hBFFF;
    #1;
    chk("rom_cs_bfff", {15'd0, bus.rom_cs}, 16'd1);
    bus.cpu_A = 16'hF000;
    #1;
    chk("rom_cs_f000", {15'd0, bus.rom_cs}, 16'd0);
    chk("din_f000", {8'h00, bus.cpu_din}, 16'h00FF);
    bus.cpu_A = 16'hC400;
    #1;
    chk("din_c400", {8'h00, bus.cpu_din}, 16'h00FF);
    bus.rom_ok = 1'b0;
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_A = 16'h1234;
    #1;
    chk("rom_cs_nomreq", {15'd0, bus.rom_cs}, 16'd0);
    tick();

    // IRQ to main CPU only on a write to 0xExxx
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_A      = 16'hE000;
    bus.cpu_wr_n   = 1'b0;
    #1;
    chk("irq_write", {15'd0, bus.mcu_irqmain}, 16'd1);
    bus.cpu_wr_n = 1'b1;
    #1;
    chk("irq_read", {15'd0, bus.mcu_irqmain}, 16'd0);
    bus.cpu_mreq_n = 1'b1;
    bus.cpu_wr_n   = 1'b0;
    #1;
    chk("irq_nomreq", {15'd0, bus.mcu_irqmain}, 16'd0);
    bus.cpu_wr_n = 1'b1;
    tick();

    // sub-CPU write, then change data while wr_n is still low: only one write may land
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_A      = 16'hC010;
    bus.cpu_dout   = 8'hA5;
    tick();
    bus.cpu_wr_n = 1'b0;
    tick(); tick();
    bus.cpu_dout = 8'h11;
    tick(); tick(); tick();
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_mreq_n = 1'b1;
    tick();
    main_read("main_rd_010", 9'h010, 8'hA5);
    sub_read("sub_rd_c010", 16'hC010, 8'hA5);

    // main write ignored while the sub-CPU owns the bus
    sub_write(16'hC020, 8'h77);
    main_write(9'h020, 8'h3C);
    sub_read("main_wr_blocked", 16'hC020, 8'h77);

    // bus granted: main write lands
    bus.mcu_halt    = 1'b1;
    bus.cpu_busak_n = 1'b0;
    #1;
    chk("busrq_n_halt", {15'd0, bus.cpu_busrq_n}, 16'd0);
    chk("ban_halted", {15'd0, bus.mcu_ban}, 16'd0);
    main_write(9'h020, 8'h3C);
    sub_read("main_wr_granted", 16'hC020, 8'h3C);

    // same-address collision: port B wins
    bus.cpu_mreq_n = 1'b0;
    bus.cpu_A      = 16'hC030;
    bus.cpu_dout   = 8'h55;
    bus.cpu_wr_n   = 1'b1;
    tick();
    bus.cpu_wr_n  = 1'b0;
    bus.main_AB   = 9'h030;
    bus.main_dout = 8'h66;
    bus.main_wrn  = 1'b0;
    bus.com_cs    = 1'b1;
    bus.main_cen  = 1'b1;
    tick();
    bus.main_wrn = 1'b1;
    bus.com_cs   = 1'b0;
    tick();
    bus.main_cen   = 1'b0;
    bus.cpu_wr_n   = 1'b1;
    bus.cpu_mreq_n = 1'b1;
    tick();
    sub_read("collision_b_wins", 16'hC030, 8'h66);
    main_read("collision_main_rd", 9'h030, 8'h66);

    bus.mcu_halt    = 1'b0;
    bus.cpu_busak_n = 1'b1;
    tick();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
